// File: rtl/fifo_reader.sv
// Pops words from an upstream FIFO and packs PACK of them into one output word.
// Optional handshake counter port word_count when FIFO_READER_WORDCNT_EN is defined.
module fifo_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int PACK       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    output logic                         fifo_rd_en,
    output logic [PACK*DATA_WIDTH-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
`ifdef FIFO_READER_WORDCNT_EN
    ,
    output logic [15:0]                  word_count
`endif
);

    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        PRESENT
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [IDX_W-1:0]             idx;
    logic [PACK*DATA_WIDTH-1:0]   pack_reg;
    logic                         handshake;

    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CAPT never looks at fifo_empty: it is the settle cycle for the lagging flag.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = READ;
            READ:    state_next = CAPT;
            CAPT:    state_next = (idx == LAST_IDX) ? PRESENT : IDLE;
            PRESENT: if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            pack_reg <= '0;
        end else if (state == CAPT) begin
            pack_reg[idx*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    assign fifo_rd_en = (state == READ);
    assign out_valid  = (state == PRESENT);
    assign out_data   = pack_reg;
    assign busy       = !((state == IDLE) && (idx == '0));

`ifdef FIFO_READER_WORDCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (handshake) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus a randomized run
// compared against a FIFO/packing reference model.
module tb_fifo_reader;

    localparam int DW = 4;
    localparam int PK = 2;
    localparam int OW = DW * PK;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          out_ready  = 1'b0;
    logic          fifo_rd_en;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          busy;
`ifdef FIFO_READER_WORDCNT_EN
    logic [15:0]   word_count;
`endif

    int checks = 0;
    int errors = 0;
    int underflows = 0;
    int pops = 0;
    int hs_count = 0;
    int hs_base = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] logq[$];

    int rd1, rd2, nrd, nval, vcyc, p0, pushed;
    logic [OW-1:0] vdata, held_data, expw;
    logic held;

    fifo_reader #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef FIFO_READER_WORDCNT_EN
        ,
        .word_count (word_count)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO: registered empty flag (one-cycle lag), data valid after pop.
    always @(posedge clk) begin
        fifo_empty <= (fq.size() == 0);
        if (fifo_rd_en) begin
            if (fq.size() == 0) underflows++;
            else fifo_data <= fq.pop_front();
        end
    end

    always @(posedge clk) begin
        if (fifo_rd_en) pops++;
        if (out_valid && out_ready) hs_count++;
    end

    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!out_valid && n < max) begin tick(); n++; end
        check({tag, "_timeout"}, out_valid, 1);
    endtask

    task automatic wait_rd(input string tag, input int max);
        int n = 0;
        while (!fifo_rd_en && n < max) begin tick(); n++; end
        check({tag, "_timeout"}, fifo_rd_en, 1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_zero(tag);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset and an idle, empty FIFO
        tick();
        do_reset("por");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_rd_en", fifo_rd_en, 0);
            check("idle_valid", out_valid, 0);
            check("idle_busy", busy, 0);
        end

        // Two words with out_ready held high
        rd1 = -1; rd2 = -1; nrd = 0; nval = 0; vcyc = -1; vdata = '0;
        push(4'h3); push(4'hA);
        out_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (fifo_rd_en) begin
                if (nrd == 0) rd1 = i; else rd2 = i;
                nrd++;
            end
            if (out_valid) begin
                nval++; vcyc = i; vdata = out_data;
            end
        end
        check("basic_rd_count", nrd, 2);
        check("basic_rd1_cycle", rd1, 2);
        check("basic_rd2_cycle", rd2, 5);
        check("basic_valid_count", nval, 1);
        check("basic_valid_cycle", vcyc, 7);
        check("basic_data", vdata, 8'hA3);

        // Backpressure: word held, a pending word popped only after handshake
        out_ready = 1'b0;
        push(4'h3); push(4'hA);
        wait_valid("bp", 20);
        check("bp_data", out_data, 8'hA3);
        push(4'h5);
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 8'hA3);
            check("bp_hold_rd_en", fifo_rd_en, 0);
        end
        check("bp_no_pop", pops, p0);
        out_ready = 1'b1;
        tick();
        check("bp_valid_drop", out_valid, 0);
        out_ready = 1'b0;
        wait_rd("bp_pop_after", 10);

        // Partial pack: one word captured, FIFO empty, waits for more
        tick();
        tick();
        p0 = pops;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("partial_busy", busy, 1);
            check("partial_rd_en", fifo_rd_en, 0);
            check("partial_valid", out_valid, 0);
        end
        check("partial_no_pop", pops, p0);
        push(4'hC);
        out_ready = 1'b1;
        wait_valid("partial", 20);
        check("partial_data", out_data, 8'hC5);
        tick();
        check("partial_valid_drop", out_valid, 0);

        // Reset while in CAPT
        push(4'h7);
        wait_rd("capt_rst", 10);
        tick();
        reset = 1'b1;
        #1;
        check_zero("capt_rst");
        tick();
        tick();
        reset = 1'b0;
        push(4'h1); push(4'h2);
        wait_valid("after_capt_rst", 20);
        check("after_capt_rst_data", out_data, 8'h21);
        tick();

        // Reset while presenting
        out_ready = 1'b0;
        push(4'h3); push(4'h4);
        wait_valid("pres_rst", 20);
        check("pres_rst_before", out_data, 8'h43);
        reset = 1'b1;
        #1;
        check_zero("pres_rst");
        tick();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        push(4'h8); push(4'h9);
        wait_valid("after_pres_rst", 20);
        check("after_pres_rst_data", out_data, 8'h98);
        tick();

        // Randomized traffic against the packing model
        out_ready = 1'b0;
        tick();
        do_reset("rand_rst");
        hs_base = hs_count;
        underflows = 0;
        pushed = 0;
        held = 1'b0;
        held_data = '0;
        logq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc < 2500 && pushed < 400 && $urandom_range(0, 3) == 0) ||
                (cyc == 2500 && (pushed % PK) != 0)) begin
                logic [DW-1:0] w;
                w = DW'($urandom_range(0, (1 << DW) - 1));
                push(w);
                logq.push_back(w);
                pushed++;
            end
            out_ready = $urandom_range(0, 1) == 1;
            if (out_valid) begin
                if (held) check("rand_hold", out_data, held_data);
                if (out_ready) begin
                    check("rand_have_words", logq.size() >= PK, 1);
                    expw = '0;
                    for (int k = 0; k < PK; k++)
                        if (logq.size() > 0) expw[k*DW +: DW] = logq.pop_front();
                    check("rand_word", out_data, expw);
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = out_data;
                end
            end else begin
                held = 1'b0;
            end
            tick();
        end
        out_ready = 1'b0;
        check("rand_all_out", logq.size(), 0);
        check("rand_fifo_drained", fq.size(), 0);
        check("rand_underflow", underflows, 0);
        check("rand_hs_count", hs_count - hs_base, pushed / PK);
`ifdef FIFO_READER_WORDCNT_EN
        check("word_count", word_count, 16'(hs_count - hs_base));
        reset = 1'b1;
        #1;
        check("word_count_rst", word_count, 0);
        tick();
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
